rob_circular_buffer: RTL and testbench

ROB_CIRCULAR_BUFFER -- requirements
Module: rob_circular_buffer

---
 rtl/rob_circular_buffer.sv | 167 ++++++++++++++++
 tb/tb_rob_circular_buffer.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_circular_buffer.sv
// Reorder buffer: circular queue of in-flight instructions with CDB writeback, operand lookup and in-order commit.
// Define ROB_FLUSH_EN to add a synchronous flush input that empties the buffer.
module rob_circular_buffer #(
  parameter int ROB_DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dispatch_valid,
  input  logic [2:0]  dispatch_op_type,
  input  logic [4:0]  dispatch_rd_addr,
  input  logic        dispatch_regf_we,
  output logic [4:0]  dispatch_rob_idx,
  output logic        rob_full,
  output logic        rob_empty,
  input  logic        cdb_valid,
  input  logic [4:0]  cdb_rob_idx,
  input  logic [31:0] cdb_data,
  input  logic [4:0]  rs1_rob_idx,
  input  logic [4:0]  rs2_rob_idx,
  output logic        rs1_rob_ready,
  output logic        rs2_rob_ready,
  output logic [31:0] rs1_rob_data,
  output logic [31:0] rs2_rob_data,
  output logic        commit_valid,
  output logic [4:0]  commit_rob_idx,
  output logic [4:0]  commit_rd_addr,
  output logic [31:0] commit_rd_data,
  output logic        commit_regf_we
`ifdef ROB_FLUSH_EN
  ,
  input  logic        flush
`endif
);

  localparam int PTR_W = $clog2(ROB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    OP_NONE   = 3'd0,
    OP_ALU    = 3'd1,
    OP_LOAD   = 3'd2,
    OP_STORE  = 3'd3,
    OP_BRANCH = 3'd4,
    OP_JUMP   = 3'd5,
    OP_MUL    = 3'd6,
    OP_DIV    = 3'd7
  } types_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DONE  = 2'd2
  } status_t;

  typedef struct packed {
    logic        valid;
    status_t     status;
    types_t      op_type;
    logic [4:0]  rd_addr;
    logic        regf_we;
    logic [31:0] rd_data;
  } rob_entry_t;

  rob_entry_t       rob [ROB_DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic             do_dispatch;
  logic             cdb_write;
  logic [PTR_W-1:0] cdb_ptr;
  logic [PTR_W-1:0] rs1_ptr;
  logic [PTR_W-1:0] rs2_ptr;
  logic             rs1_ent_valid;
  logic             rs2_ent_valid;

  // Indices at or above ROB_DEPTH never name a live entry when the ROB is narrower than 32.
  function automatic logic idx_in_range(input logic [4:0] idx);
    return {1'b0, idx} < 6'(ROB_DEPTH);
  endfunction

  // A same-cycle CDB result takes priority over the stored value so consumers see it immediately.
  function automatic logic [32:0] operand_lookup(input logic        cdb_hit,
                                                 input logic        ent_valid,
                                                 input logic        ent_done,
                                                 input logic [31:0] ent_data,
                                                 input logic [31:0] bus_data);
    if (cdb_hit && ent_valid)
      return {1'b1, bus_data};
    else if (ent_valid && ent_done)
      return {1'b1, ent_data};
    return 33'd0;
  endfunction

  assign rob_full         = (count == CNT_W'(ROB_DEPTH));
  assign rob_empty        = (count == '0);
  assign dispatch_rob_idx = 5'(tail);
  assign commit_rob_idx   = 5'(head);

  assign commit_valid   = rob[head].valid && (rob[head].status == ST_DONE);
  assign commit_rd_addr = commit_valid ? rob[head].rd_addr : 5'd0;
  assign commit_rd_data = commit_valid ? rob[head].rd_data : 32'd0;
  assign commit_regf_we = commit_valid && rob[head].regf_we;

  assign do_dispatch = dispatch_valid && !rob_full;

  assign cdb_ptr   = cdb_rob_idx[PTR_W-1:0];
  assign cdb_write = cdb_valid && idx_in_range(cdb_rob_idx) &&
                     rob[cdb_ptr].valid && (rob[cdb_ptr].status == ST_WAIT);

  assign rs1_ptr       = rs1_rob_idx[PTR_W-1:0];
  assign rs2_ptr       = rs2_rob_idx[PTR_W-1:0];
  assign rs1_ent_valid = idx_in_range(rs1_rob_idx) && rob[rs1_ptr].valid;
  assign rs2_ent_valid = idx_in_range(rs2_rob_idx) && rob[rs2_ptr].valid;

  assign {rs1_rob_ready, rs1_rob_data} =
    operand_lookup(cdb_valid && (cdb_rob_idx == rs1_rob_idx), rs1_ent_valid,
                   rob[rs1_ptr].status == ST_DONE, rob[rs1_ptr].rd_data, cdb_data);
  assign {rs2_rob_ready, rs2_rob_data} =
    operand_lookup(cdb_valid && (cdb_rob_idx == rs2_rob_idx), rs2_ent_valid,
                   rob[rs2_ptr].status == ST_DONE, rob[rs2_ptr].rd_data, cdb_data);

  // Commit, CDB and dispatch never touch the same entry in one cycle: commit needs done,
  // CDB needs a waiting entry, and dispatch needs a free one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ROB_DEPTH; i++) rob[i] <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end
`ifdef ROB_FLUSH_EN
    else if (flush) begin
      for (int i = 0; i < ROB_DEPTH; i++) rob[i] <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end
`endif
    else begin
      if (commit_valid) begin
        rob[head].valid  <= 1'b0;
        rob[head].status <= ST_EMPTY;
        head             <= head + 1'b1;
      end
      if (cdb_write) begin
        rob[cdb_ptr].status  <= ST_DONE;
        rob[cdb_ptr].rd_data <= cdb_data;
      end
      if (do_dispatch) begin
        rob[tail] <= '{valid:   1'b1,
                       status:  ST_WAIT,
                       op_type: types_t'(dispatch_op_type),
                       rd_addr: dispatch_rd_addr,
                       regf_we: dispatch_regf_we,
                       rd_data: 32'd0};
        tail      <= tail + 1'b1;
      end
      unique case ({do_dispatch, commit_valid})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_rob_circular_buffer.sv
// Self-checking bench for rob_circular_buffer: directed vector table, corner-case sequences and
// randomized traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_rob_circular_buffer;
  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dispatch_valid = 1'b0;
  logic [2:0]  dispatch_op_type = 3'd0;
  logic [4:0]  dispatch_rd_addr = 5'd0;
  logic        dispatch_regf_we = 1'b0;
  logic [4:0]  dispatch_rob_idx;
  logic        rob_full, rob_empty;
  logic        cdb_valid = 1'b0;
  logic [4:0]  cdb_rob_idx = 5'd0;
  logic [31:0] cdb_data = 32'd0;
  logic [4:0]  rs1_rob_idx = 5'd0, rs2_rob_idx = 5'd0;
  logic        rs1_rob_ready, rs2_rob_ready;
  logic [31:0] rs1_rob_data, rs2_rob_data;
  logic        commit_valid;
  logic [4:0]  commit_rob_idx, commit_rd_addr;
  logic [31:0] commit_rd_data;
  logic        commit_regf_we;
`ifdef ROB_FLUSH_EN
  logic        flush = 1'b0;
`endif

  always #5 clk = ~clk;

  rob_circular_buffer #(.ROB_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .dispatch_valid(dispatch_valid), .dispatch_op_type(dispatch_op_type),
    .dispatch_rd_addr(dispatch_rd_addr), .dispatch_regf_we(dispatch_regf_we),
    .dispatch_rob_idx(dispatch_rob_idx), .rob_full(rob_full), .rob_empty(rob_empty),
    .cdb_valid(cdb_valid), .cdb_rob_idx(cdb_rob_idx), .cdb_data(cdb_data),
    .rs1_rob_idx(rs1_rob_idx), .rs2_rob_idx(rs2_rob_idx),
    .rs1_rob_ready(rs1_rob_ready), .rs2_rob_ready(rs2_rob_ready),
    .rs1_rob_data(rs1_rob_data), .rs2_rob_data(rs2_rob_data),
    .commit_valid(commit_valid), .commit_rob_idx(commit_rob_idx),
    .commit_rd_addr(commit_rd_addr), .commit_rd_data(commit_rd_data),
    .commit_regf_we(commit_regf_we)
`ifdef ROB_FLUSH_EN
    , .flush(flush)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: program-order queue of allocated indices plus per-index state.
  int          q[$];
  int          m_tail;
  bit          mvalid[DEPTH];
  bit          mdone[DEPTH];
  logic [31:0] mdata[DEPTH];
  logic [4:0]  mrd[DEPTH];
  bit          mwe[DEPTH];

  function automatic void model_clear();
    q.delete();
    m_tail = 0;
    for (int i = 0; i < DEPTH; i++) begin
      mvalid[i] = 1'b0; mdone[i] = 1'b0; mdata[i] = 32'd0; mrd[i] = 5'd0; mwe[i] = 1'b0;
    end
  endfunction

  function automatic bit m_commit();
    return (q.size() > 0) && mdone[q[0]];
  endfunction

  function automatic logic [32:0] m_lookup(input logic [4:0] idx);
    int i;
    i = int'(idx);
    if (i >= DEPTH) return 33'd0;
    if (cdb_valid && cdb_rob_idx == idx && mvalid[i]) return {1'b1, cdb_data};
    if (mvalid[i] && mdone[i]) return {1'b1, mdata[i]};
    return 33'd0;
  endfunction

  task automatic compare_all();
    int h;
    bit cv;
    logic [32:0] l1, l2;
    h  = (q.size() > 0) ? q[0] : m_tail;
    cv = m_commit();
    l1 = m_lookup(rs1_rob_idx);
    l2 = m_lookup(rs2_rob_idx);
    check("dispatch_rob_idx", 32'(dispatch_rob_idx), 32'(m_tail));
    check("rob_full", 32'(rob_full), 32'(q.size() == DEPTH));
    check("rob_empty", 32'(rob_empty), 32'(q.size() == 0));
    check("commit_valid", 32'(commit_valid), 32'(cv));
    check("commit_rob_idx", 32'(commit_rob_idx), 32'(h));
    check("commit_rd_addr", 32'(commit_rd_addr), cv ? 32'(mrd[h]) : 32'd0);
    check("commit_rd_data", commit_rd_data, cv ? mdata[h] : 32'd0);
    check("commit_regf_we", 32'(commit_regf_we), cv ? 32'(mwe[h]) : 32'd0);
    check("rs1_rob_ready", 32'(rs1_rob_ready), 32'(l1[32]));
    check("rs1_rob_data", rs1_rob_data, l1[31:0]);
    check("rs2_rob_ready", 32'(rs2_rob_ready), 32'(l2[32]));
    check("rs2_rob_data", rs2_rob_data, l2[31:0]);
  endtask

  task automatic model_edge();
    bit cv, dd, cw;
    int ci;
`ifdef ROB_FLUSH_EN
    if (flush) begin
      model_clear();
      return;
    end
`endif
    cv = m_commit();
    dd = dispatch_valid && (q.size() < DEPTH);
    ci = int'(cdb_rob_idx);
    cw = cdb_valid && (ci < DEPTH) && mvalid[ci] && !mdone[ci];
    if (cw) begin
      mdone[ci] = 1'b1;
      mdata[ci] = cdb_data;
    end
    if (cv) begin
      mvalid[q[0]] = 1'b0;
      mdone[q[0]]  = 1'b0;
      void'(q.pop_front());
    end
    if (dd) begin
      mvalid[m_tail] = 1'b1;
      mdone[m_tail]  = 1'b0;
      mdata[m_tail]  = 32'd0;
      mrd[m_tail]    = dispatch_rd_addr;
      mwe[m_tail]    = dispatch_regf_we;
      q.push_back(m_tail);
      m_tail = (m_tail + 1) % DEPTH;
    end
  endtask

  task automatic set_idle();
    dispatch_valid = 1'b0; dispatch_op_type = 3'd0; dispatch_rd_addr = 5'd0; dispatch_regf_we = 1'b0;
    cdb_valid = 1'b0; cdb_rob_idx = 5'd0; cdb_data = 32'd0;
    rs1_rob_idx = 5'd0; rs2_rob_idx = 5'd0;
`ifdef ROB_FLUSH_EN
    flush = 1'b0;
`endif
  endtask

  // Called at a falling edge with inputs already applied; returns at the next falling edge.
  task automatic tick();
    #1;
    compare_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    model_clear();
    #1;
    compare_all();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic dispatch_one(input logic [4:0] rd);
    set_idle();
    dispatch_valid = 1'b1; dispatch_op_type = 3'd1; dispatch_rd_addr = rd; dispatch_regf_we = 1'b1;
    tick();
  endtask

  typedef struct {
    logic        dv;
    logic [4:0]  rd;
    logic        cv;
    logic [4:0]  cidx;
    logic [31:0] cdata;
    logic [4:0]  rs1;
    logic [4:0]  e_didx;
    logic        e_empty;
    logic        e_cv;
    logic [4:0]  e_cidx;
    logic [31:0] e_cdata;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{1'b1, 5'd1, 1'b0, 5'd0, 32'h0,  5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0};
    tbl[1] = '{1'b1, 5'd2, 1'b0, 5'd0, 32'h0,  5'd0, 5'd1, 1'b0, 1'b0, 5'd0, 32'h0};
    tbl[2] = '{1'b1, 5'd3, 1'b0, 5'd0, 32'h0,  5'd0, 5'd2, 1'b0, 1'b0, 5'd0, 32'h0};
    tbl[3] = '{1'b0, 5'd0, 1'b0, 5'd0, 32'h0,  5'd1, 5'd3, 1'b0, 1'b0, 5'd0, 32'h0};
    tbl[4] = '{1'b0, 5'd0, 1'b1, 5'd1, 32'hAA, 5'd1, 5'd3, 1'b0, 1'b0, 5'd0, 32'h0};
    tbl[5] = '{1'b0, 5'd0, 1'b1, 5'd0, 32'h55, 5'd0, 5'd3, 1'b0, 1'b0, 5'd0, 32'h0};
    tbl[6] = '{1'b0, 5'd0, 1'b0, 5'd0, 32'h0,  5'd1, 5'd3, 1'b0, 1'b1, 5'd0, 32'h55};
    tbl[7] = '{1'b0, 5'd0, 1'b0, 5'd0, 32'h0,  5'd1, 5'd3, 1'b0, 1'b1, 5'd1, 32'hAA};
    tbl[8] = '{1'b0, 5'd0, 1'b0, 5'd0, 32'h0,  5'd2, 5'd3, 1'b0, 1'b0, 5'd2, 32'h0};

    @(negedge clk);
    do_reset();

    // Dispatch three ops, out-of-order completion, in-order commit.
    for (int i = 0; i < 9; i++) begin
      set_idle();
      dispatch_valid = tbl[i].dv; dispatch_op_type = 3'd1;
      dispatch_rd_addr = tbl[i].rd; dispatch_regf_we = tbl[i].dv;
      cdb_valid = tbl[i].cv; cdb_rob_idx = tbl[i].cidx; cdb_data = tbl[i].cdata;
      rs1_rob_idx = tbl[i].rs1;
      #1;
      check($sformatf("tbl%0d dispatch_rob_idx", i), 32'(dispatch_rob_idx), 32'(tbl[i].e_didx));
      check($sformatf("tbl%0d rob_empty", i), 32'(rob_empty), 32'(tbl[i].e_empty));
      check($sformatf("tbl%0d commit_valid", i), 32'(commit_valid), 32'(tbl[i].e_cv));
      check($sformatf("tbl%0d commit_rob_idx", i), 32'(commit_rob_idx), 32'(tbl[i].e_cidx));
      check($sformatf("tbl%0d commit_rd_data", i), commit_rd_data, tbl[i].e_cdata);
      tick();
    end

    // Same-cycle CDB forwarding, then stored data, then an unallocated index.
    do_reset();
    for (int i = 0; i < 5; i++) dispatch_one(5'(i + 10));
    set_idle();
    cdb_valid = 1'b1; cdb_rob_idx = 5'd4; cdb_data = 32'h1234; rs1_rob_idx = 5'd4; rs2_rob_idx = 5'd3;
    #1;
    check("fwd rs1_rob_ready", 32'(rs1_rob_ready), 32'd1);
    check("fwd rs1_rob_data", rs1_rob_data, 32'h1234);
    check("fwd rs2_rob_ready", 32'(rs2_rob_ready), 32'd0);
    tick();
    set_idle();
    rs1_rob_idx = 5'd4;
    #1;
    check("stored rs1_rob_ready", 32'(rs1_rob_ready), 32'd1);
    check("stored rs1_rob_data", rs1_rob_data, 32'h1234);
    tick();
    set_idle();
    cdb_valid = 1'b1; cdb_rob_idx = 5'd9; cdb_data = 32'hDEAD; rs1_rob_idx = 5'd9;
    #1;
    check("unalloc cdb rs1_rob_ready", 32'(rs1_rob_ready), 32'd0);
    tick();
    set_idle();
    rs1_rob_idx = 5'd9;
    #1;
    check("unalloc after rs1_rob_ready", 32'(rs1_rob_ready), 32'd0);
    check("unalloc after dispatch_rob_idx", 32'(dispatch_rob_idx), 32'd5);
    tick();

    // Fill to full, drop overflow, no commit-to-dispatch bypass, wrap.
    do_reset();
    for (int i = 0; i < DEPTH; i++) dispatch_one(5'(i));
    set_idle();
    #1;
    check("fill rob_full", 32'(rob_full), 32'd1);
    check("fill dispatch_rob_idx", 32'(dispatch_rob_idx), 32'd0);
    dispatch_valid = 1'b1; dispatch_rd_addr = 5'd31;
    tick();
    set_idle();
    #1;
    check("overflow rob_full", 32'(rob_full), 32'd1);
    check("overflow dispatch_rob_idx", 32'(dispatch_rob_idx), 32'd0);
    cdb_valid = 1'b1; cdb_rob_idx = 5'd0; cdb_data = 32'h77;
    tick();
    set_idle();
    dispatch_valid = 1'b1; dispatch_rd_addr = 5'd7;
    #1;
    check("full commit_valid", 32'(commit_valid), 32'd1);
    check("full commit_rd_data", commit_rd_data, 32'h77);
    tick();
    set_idle();
    #1;
    check("after commit rob_full", 32'(rob_full), 32'd0);
    check("wrap dispatch_rob_idx", 32'(dispatch_rob_idx), 32'd0);
    dispatch_valid = 1'b1; dispatch_rd_addr = 5'd8;
    tick();
    set_idle();
    #1;
    check("wrap refill rob_full", 32'(rob_full), 32'd1);
    check("wrap next dispatch_rob_idx", 32'(dispatch_rob_idx), 32'd1);

    // Reset asserted mid-cycle with traffic in flight.
    do_reset();
    for (int i = 0; i < 3; i++) dispatch_one(5'(i + 1));
    set_idle();
    dispatch_valid = 1'b1; cdb_valid = 1'b1; cdb_rob_idx = 5'd0; cdb_data = 32'h99;
    #3;
    rst = 1'b1;
    model_clear();
    #1;
    compare_all();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    set_idle();
    dispatch_valid = 1'b1; dispatch_rd_addr = 5'd4;
    #1;
    check("post-reset dispatch_rob_idx", 32'(dispatch_rob_idx), 32'd0);
    check("post-reset rob_empty", 32'(rob_empty), 32'd1);
    tick();

`ifdef ROB_FLUSH_EN
    // Flush overrides a same-cycle dispatch and CDB write.
    do_reset();
    for (int i = 0; i < 5; i++) dispatch_one(5'(i + 1));
    set_idle();
    flush = 1'b1; dispatch_valid = 1'b1; cdb_valid = 1'b1; cdb_rob_idx = 5'd0; cdb_data = 32'h5;
    tick();
    set_idle();
    #1;
    check("flush rob_empty", 32'(rob_empty), 32'd1);
    check("flush dispatch_rob_idx", 32'(dispatch_rob_idx), 32'd0);
    tick();
`endif

    // Randomized traffic against the reference model.
    do_reset();
    for (int n = 0; n < 800; n++) begin
      set_idle();
      dispatch_valid   = ($urandom_range(0, 99) < 60);
      dispatch_op_type = 3'($urandom_range(0, 7));
      dispatch_rd_addr = 5'($urandom_range(0, 31));
      dispatch_regf_we = 1'($urandom_range(0, 1));
      cdb_valid        = ($urandom_range(0, 99) < 55);
      cdb_data         = $urandom;
      if (q.size() > 0 && $urandom_range(0, 99) < 75)
        cdb_rob_idx = 5'(q[$urandom_range(0, q.size() - 1)]);
      else
        cdb_rob_idx = 5'($urandom_range(0, 31));
      if (q.size() > 0 && $urandom_range(0, 99) < 70)
        rs1_rob_idx = 5'(q[$urandom_range(0, q.size() - 1)]);
      else
        rs1_rob_idx = 5'($urandom_range(0, 31));
      rs2_rob_idx = ($urandom_range(0, 99) < 30) ? cdb_rob_idx : 5'($urandom_range(0, 31));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
